// File: rtl/iic_reg_wr_arbiter.sv
// iic_reg_wr_arbiter: shares local write access to the two-register I2C slave
// bank between two requesters, defers while the I2C bus is active, and
// verifies each write by reading the register back.
module iic_reg_wr_arbiter #(
    parameter int unsigned VERIFY_DLY   = 2,
    parameter int unsigned BUSY_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rq0_valid,
    input  logic       rq0_addr,
    input  logic [7:0] rq0_data,
    output logic       rq0_ready,
    output logic       rq0_done,
    output logic       rq0_err,
    input  logic       rq1_valid,
    input  logic       rq1_addr,
    input  logic [7:0] rq1_data,
    output logic       rq1_ready,
    output logic       rq1_done,
    output logic       rq1_err,
    input  logic       i2c_busy,
    input  logic [7:0] reg0_rd,
    input  logic [7:0] reg1_rd,
    output logic       reg0_wr_en,
    output logic       reg1_wr_en,
    output logic [7:0] reg0_wdata,
    output logic [7:0] reg1_wdata,
    output logic       arb_busy
);

    localparam int unsigned VCNT_W = 4;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [VCNT_W-1:0] VER_LAST  = VCNT_W'(VERIFY_DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_GRANT,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              id_q;
    logic              addr_q;
    logic [7:0]        data_q;
    logic              err_l_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [VCNT_W-1:0] vcnt_q;
    logic [1:0]        ready_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [1:0]        wr_en_q;
    logic [7:0]        wdata0_q;
    logic [7:0]        wdata1_q;
    logic              arb_busy_q;

    logic              win_c;
    logic              win_addr_c;
    logic [7:0]        win_data_c;
    logic [7:0]        rd_sel_c;

    // Round-robin pick: the sole requester, or the one not granted last time.
    assign win_c      = (rq0_valid && rq1_valid) ? ~last_grant_q : rq1_valid;
    assign win_addr_c = win_c ? rq1_addr : rq0_addr;
    assign win_data_c = win_c ? rq1_data : rq0_data;
    assign rd_sel_c   = addr_q ? reg1_rd : reg0_rd;

    // Arbitration / write / readback-verify sequencer with registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            id_q         <= 1'b0;
            addr_q       <= 1'b0;
            data_q       <= 8'h00;
            err_l_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            vcnt_q       <= '0;
            ready_q      <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            wr_en_q      <= 2'b00;
            wdata0_q     <= 8'h00;
            wdata1_q     <= 8'h00;
            arb_busy_q   <= 1'b0;
        end else begin
            ready_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            wr_en_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (rq0_valid || rq1_valid) begin
                        id_q       <= win_c;
                        addr_q     <= win_addr_c;
                        data_q     <= win_data_c;
                        err_l_q    <= 1'b0;
                        arb_busy_q <= 1'b1;
                        if (!i2c_busy) begin
                            state_q        <= S_GRANT;
                            ready_q[win_c] <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT_BUS;
                            wait_cnt_q <= '0;
                        end
                    end
                end
                S_WAIT_BUS: begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    if (!i2c_busy) begin
                        state_q       <= S_GRANT;
                        ready_q[id_q] <= 1'b1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Timed out: still hand out ready so done never precedes it.
                        state_q       <= S_GRANT;
                        err_l_q       <= 1'b1;
                        ready_q[id_q] <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (err_l_q) begin
                        state_q      <= S_DONE;
                        done_q[id_q] <= 1'b1;
                        err_q[id_q]  <= 1'b1;
                    end else begin
                        state_q         <= S_WRITE;
                        wr_en_q[addr_q] <= 1'b1;
                        if (addr_q) begin
                            wdata1_q <= data_q;
                        end else begin
                            wdata0_q <= data_q;
                        end
                    end
                end
                S_WRITE: begin
                    state_q <= S_VERIFY;
                    vcnt_q  <= '0;
                end
                S_VERIFY: begin
                    if (vcnt_q == VER_LAST) begin
                        state_q      <= S_DONE;
                        done_q[id_q] <= 1'b1;
                        err_q[id_q]  <= err_l_q | (rd_sel_c != data_q);
                    end else begin
                        vcnt_q <= vcnt_q + VCNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    last_grant_q <= id_q;
                    err_l_q      <= 1'b0;
                    arb_busy_q   <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rq0_ready  = ready_q[0];
    assign rq1_ready  = ready_q[1];
    assign rq0_done   = done_q[0];
    assign rq1_done   = done_q[1];
    assign rq0_err    = err_q[0];
    assign rq1_err    = err_q[1];
    assign reg0_wr_en = wr_en_q[0];
    assign reg1_wr_en = wr_en_q[1];
    assign reg0_wdata = wdata0_q;
    assign reg1_wdata = wdata1_q;
    assign arb_busy   = arb_busy_q;

endmodule

// File: tb/tb_iic_reg_wr_arbiter.sv
// Testbench for iic_reg_wr_arbiter: stimulus pushes expected transactions into a
// queue, an independent monitor checks ready/write/done events against it.
module tb_iic_reg_wr_arbiter;

    localparam int VD = 2;
    localparam int TO = 16;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rq0_valid = 1'b0, rq0_addr = 1'b0;
    logic [7:0] rq0_data = 8'h00;
    logic       rq1_valid = 1'b0, rq1_addr = 1'b0;
    logic [7:0] rq1_data = 8'h00;
    logic       rq0_ready, rq0_done, rq0_err;
    logic       rq1_ready, rq1_done, rq1_err;
    logic       i2c_busy = 1'b0;
    logic [7:0] reg0_rd, reg1_rd;
    logic       reg0_wr_en, reg1_wr_en;
    logic [7:0] reg0_wdata, reg1_wdata;
    logic       arb_busy;

    iic_reg_wr_arbiter #(.VERIFY_DLY(VD), .BUSY_TIMEOUT(TO), .CNT_W(5)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_addr(rq0_addr), .rq0_data(rq0_data),
        .rq0_ready(rq0_ready), .rq0_done(rq0_done), .rq0_err(rq0_err),
        .rq1_valid(rq1_valid), .rq1_addr(rq1_addr), .rq1_data(rq1_data),
        .rq1_ready(rq1_ready), .rq1_done(rq1_done), .rq1_err(rq1_err),
        .i2c_busy(i2c_busy), .reg0_rd(reg0_rd), .reg1_rd(reg1_rd),
        .reg0_wr_en(reg0_wr_en), .reg1_wr_en(reg1_wr_en),
        .reg0_wdata(reg0_wdata), .reg1_wdata(reg1_wdata),
        .arb_busy(arb_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Slave register bank; corrupt models an I2C master clobbering the readback.
    logic [7:0] regs [2] = '{8'h00, 8'h00};
    logic       corrupt = 1'b0;
    always @(posedge sys_clk) begin
        if (reg0_wr_en) regs[0] <= reg0_wdata;
        if (reg1_wr_en) regs[1] <= reg1_wdata;
    end
    assign reg0_rd = corrupt ? 8'h00 : regs[0];
    assign reg1_rd = corrupt ? 8'h00 : regs[1];

    typedef struct {
        int id;
        int addr;
        int data;
        int err;
        bit wr;
        int rdy_cyc;   // >=0 exact cycle, -2 means two cycles after previous done
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor-side state (reset-aware, also touched by the reset scenario).
    bit   op_open   = 1'b0;
    exp_t cur;
    int   rdy_at    = 0;
    int   wr_at     = 0;
    int   done_at   = -100;
    int   mdl_wdata [2] = '{0, 0};
    int   lg        = 1;   // model of which requester was granted last

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations on ready, checks the write and done that follow.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (rq0_ready || rq1_ready) begin
                if (rq0_ready && rq1_ready) fail_evt("dual_ready");
                else if (op_open) fail_evt("ready_before_done");
                else if (exp_q.size() == 0) fail_evt("ready_unexpected");
                else begin
                    cur = exp_q.pop_front();
                    chk("ready_id", int'(rq1_ready), cur.id);
                    if (cur.rdy_cyc >= 0) chk("ready_cycle", cyc, cur.rdy_cyc);
                    else chk("ready_b2b_cycle", cyc, done_at + 2);
                    op_open = 1'b1;
                    rdy_at  = cyc;
                end
            end
            if (reg0_wr_en || reg1_wr_en) begin
                if (reg0_wr_en && reg1_wr_en) fail_evt("dual_wr_en");
                else if (!op_open || !cur.wr) fail_evt("wr_en_unexpected");
                else begin
                    chk("wr_addr", int'(reg1_wr_en), cur.addr);
                    chk("wr_data", int'(reg1_wr_en ? reg1_wdata : reg0_wdata), cur.data);
                    chk("wr_other_wdata", int'(reg1_wr_en ? reg0_wdata : reg1_wdata),
                        mdl_wdata[reg1_wr_en ? 0 : 1]);
                    chk("wr_cycle", cyc, rdy_at + 1);
                    chk("wr_while_busy", int'(i2c_busy), 0);
                    mdl_wdata[cur.addr] = cur.data;
                    wr_at = cyc;
                end
            end
            if (rq0_done || rq1_done) begin
                if (rq0_done && rq1_done) fail_evt("dual_done");
                else if (!op_open) fail_evt("done_unexpected");
                else begin
                    chk("done_id", int'(rq1_done), cur.id);
                    chk("done_err", int'(rq1_done ? rq1_err : rq0_err), cur.err);
                    chk("done_cycle", cyc, cur.wr ? wr_at + 1 + VD : rdy_at + 1);
                    op_open = 1'b0;
                    done_at = cyc;
                end
            end
            if ((rq0_err && !rq0_done) || (rq1_err && !rq1_done)) fail_evt("err_without_done");
        end
    end

    // One arbitration round: push model expectations, drive requesters, wait for dones.
    task automatic round(input bit v0, input bit v1, input logic a0, input logic [7:0] d0,
                         input logic a1, input logic [7:0] d1, input int busy_len,
                         input bit corr);
        int order[$];
        int c, busy_left, dones, need, id, d;
        exp_t e;
        @(negedge sys_clk);
        c = cyc;
        corrupt = corr;
        if (v0 && v1) order = '{1 - lg, lg};
        else order = '{v1 ? 1 : 0};
        foreach (order[i]) begin
            id = order[i];
            d  = id ? int'(d1) : int'(d0);
            e.id   = id;
            e.addr = id ? int'(a1) : int'(a0);
            e.data = d;
            if (i == 0 && busy_len > TO) begin
                e.err = 1; e.wr = 1'b0; e.rdy_cyc = c + TO + 1;
            end else begin
                e.err = (corr && d != 0) ? 1 : 0; e.wr = 1'b1;
                e.rdy_cyc = (i == 0) ? c + busy_len + 1 : -2;
            end
            exp_q.push_back(e);
            lg = id;
        end
        need = order.size();
        rq0_valid = v0; rq0_addr = a0; rq0_data = d0;
        rq1_valid = v1; rq1_addr = a1; rq1_data = d1;
        i2c_busy  = (busy_len > 0);
        busy_left = busy_len;
        dones = 0;
        for (int k = 0; k < 200 && dones < need; k++) begin
            @(negedge sys_clk);
            if (rq0_ready) rq0_valid = 1'b0;
            if (rq1_ready) rq1_valid = 1'b0;
            if (rq0_done || rq1_done) dones++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) i2c_busy = 1'b0;
            end
        end
        if (dones < need) begin
            n_tests++; n_fail++;
            $display("FAIL round_timeout: got %0d dones expected %0d", dones, need);
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0; i2c_busy = 1'b0;
        @(negedge sys_clk);
        chk("idle_arb_busy", int'(arb_busy), 0);
        corrupt = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({rq0_ready, rq0_done, rq0_err, rq1_ready, rq1_done, rq1_err,
                     reg0_wr_en, reg1_wr_en, reg0_wdata, reg1_wdata, arb_busy});
    endfunction

    initial begin
        logic [7:0] rd;
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_reset_outputs", all_outs(), 0);

        // Single write, no contention: ready c+1, wr_en c+2, done c+5
        round(1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 0, 1'b0);

        // Simultaneous requests repeated: grants alternate 0,1,...
        for (int i = 0; i < 4; i++)
            round(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 0, 1'b0);

        // Bus busy for a while (inside the timeout window), then write completes
        round(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 12, 1'b0);

        // Bus held past the timeout: ready then done with err, no write
        round(1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 40, 1'b0);

        // Readback clobbered: err reported, wdata keeps the written value
        round(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 0, 1'b1);
        chk("wdata_hold_after_err", int'(reg0_wdata), 8'h5A);

        // Reset during VERIFY abandons the operation silently
        begin
            exp_t e;
            @(negedge sys_clk);
            e.id = 0; e.addr = 1; e.data = 8'h77; e.err = 0; e.wr = 1'b1; e.rdy_cyc = cyc + 1;
            exp_q.push_back(e);
            rq0_valid = 1'b1; rq0_addr = 1'b1; rq0_data = 8'h77;
            for (int k = 0; k < 20 && !reg1_wr_en; k++) begin
                @(negedge sys_clk);
                if (rq0_ready) rq0_valid = 1'b0;
            end
            chk("reset_test_write_seen", int'(reg1_wr_en), 1);
            @(negedge sys_clk);
            #1 rst_n = 1'b0;
            #1 chk("reset_midop_outputs", all_outs(), 0);
            op_open = 1'b0;
            mdl_wdata = '{0, 0};
            lg = 1;
            repeat (4) @(negedge sys_clk);
            chk("reset_hold_outputs", all_outs(), 0);
            rst_n = 1'b1;
            repeat (6) @(negedge sys_clk);
            chk("no_done_after_reset", int'(arb_busy), 0);
        end
        round(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22, 0, 1'b0);

        // Randomized rounds
        for (int i = 0; i < 40; i++) begin
            int v;
            v = $urandom_range(1, 3);
            rd = 8'($urandom);
            round(v[0], v[1], 1'($urandom_range(0, 1)), rd,
                  1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                  ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge sys_clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("no_open_op", int'(op_open), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
